// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths, access-size enum and alignment helper
// Contents:
//   WB_ADDR_W / WB_DATA_W / WB_SEL_W  bus widths
//   size_t                            access size: BYTE=00, HALF=01, WORD=10, 11 reserved
//   is_illegal()                      1 for reserved size or a misaligned address offset
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  function automatic logic is_illegal(input size_t size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return (offset != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wb_bus.sv
// rtl/wb_bus.sv - Wishbone classic bus signal bundle
// Signals: addr, wdata, we, stb, cyc, sel (initiator to target); rdata, ack, err (target to initiator)
// Modports: master (initiator view), slave (target view)
interface wb_bus;

  logic [wb_pkg::WB_ADDR_W-1:0] addr;
  logic [wb_pkg::WB_DATA_W-1:0] wdata;
  logic [wb_pkg::WB_DATA_W-1:0] rdata;
  logic [wb_pkg::WB_SEL_W-1:0]  sel;
  logic                         we;
  logic                         stb;
  logic                         cyc;
  logic                         ack;
  logic                         err;

  modport master (
    output addr, wdata, we, stb, cyc, sel,
    input  rdata, ack, err
  );

  modport slave (
    input  addr, wdata, we, stb, cyc, sel,
    output rdata, ack, err
  );

endinterface

// File: rtl/wb_lane_align.sv
// rtl/wb_lane_align.sv - byte-lane select, store-data replication and load-data extraction
// Ports (all combinational):
//   size, offset, is_signed   access size, address[1:0], sign-extend loads
//   wdata_in -> wdata_out     right-aligned store data replicated across the lanes
//   rdata_in -> rdata_out     bus read data shifted down, masked and extended
//   sel                       byte-lane enables
// A reserved size yields all-zero outputs.
module wb_lane_align
  import wb_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  sel,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata_in >> {offset, 3'b000};
    sel       = 4'b0000;
    wdata_out = 32'h0;
    rdata_out = 32'h0;
    case (size)
      SIZE_BYTE: begin
        sel       = 4'b0001 << offset;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        sel       = 4'b0011 << offset;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        sel       = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_master_port.sv
// rtl/wb_master_port.sv - single-outstanding load/store to Wishbone classic initiator
// Optional feature macro: WB_MASTER_TIMEOUT_EN (abort a bus cycle after TIMEOUT_CYCLES)
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   req_valid/req_ready              request handshake (accept on valid && ready)
//   req_we, req_addr, req_size,
//   req_signed, req_wdata            request fields, sampled only on the accept edge
//   rsp_valid, rsp_rdata, rsp_err    one-cycle registered response
//   bus                              Wishbone initiator modport
module wb_master_port
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  wb_bus.master       bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d;
  size_t       size_q, size_d;
  logic        signed_q, signed_d;
  logic        req_ready_q, req_ready_d;
  logic        cyc_q, cyc_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  // One aligner serves both directions: in IDLE it sees the incoming request
  // (sel/wdata are captured on accept), elsewhere it sees the latched access
  // so the read path extracts from bus.rdata at termination.
  size_t       al_size;
  logic [1:0]  al_off;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign al_size = (state_q == ST_IDLE) ? size_t'(req_size) : size_q;
  assign al_off  = (state_q == ST_IDLE) ? req_addr[1:0]     : off_q;

  wb_lane_align u_align (
    .size      (al_size),
    .offset    (al_off),
    .is_signed (signed_q),
    .wdata_in  (req_wdata),
    .rdata_in  (bus.rdata),
    .sel       (al_sel),
    .wdata_out (al_wdata),
    .rdata_out (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    off_d       = off_q;
    size_d      = size_q;
    signed_d    = signed_q;
    cyc_d       = cyc_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d     = req_we;
          off_d    = req_addr[1:0];
          size_d   = size_t'(req_size);
          signed_d = req_signed;
          if (is_illegal(size_t'(req_size), req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ST_BUS;
            cyc_d       = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_wdata_d = al_wdata;
            bus_sel_d   = al_sel;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_d       = 32'h0;
`endif
          end
        end
      end

      ST_BUS: begin
        if (bus.ack || bus.err) begin
          // err wins when both are asserted together
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          bus_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.err;
          if (!bus.err && !we_q) begin
            rsp_rdata_d = al_rdata;
          end
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          bus_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SIZE_BYTE;
      signed_q    <= 1'b0;
      req_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_sel_q   <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      off_q       <= off_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      req_ready_q <= req_ready_d;
      cyc_q       <= cyc_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  assign bus.cyc   = cyc_q;
  assign bus.stb   = cyc_q;
  assign bus.we    = bus_we_q;
  assign bus.addr  = bus_addr_q;
  assign bus.wdata = bus_wdata_q;
  assign bus.sel   = bus_sel_q;

endmodule

// File: tb/tb_wb_master_port.sv
// tb/tb_wb_master_port.sv - self-checking bench for wb_master_port
module tb_wb_master_port;
  import wb_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  wb_bus bus_if ();

  always #5 clk = ~clk;

  wb_master_port #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus        (bus_if)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] srd;
    logic        ack;
    logic        err;
    logic        legal;
    logic [3:0]  sel;
    logic [31:0] bwd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs[11];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: derived from byte counts and plain arithmetic.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] wdata, input logic [31:0] srd,
                                input logic s_err, output logic legal, output logic [3:0] sel,
                                output logic [31:0] bwd, output logic [31:0] rd, output logic er);
    int off;
    int nb;
    logic [63:0] v;
    logic [63:0] m;
    off = int'(addr % 4);
    nb  = (size == 2'd3) ? 0 : (1 << size);
    legal = (nb != 0) && ((addr % nb) == 0);
    sel = 4'b0000;
    bwd = 32'h0;
    if (legal) begin
      sel = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) bwd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end
    er = !legal || s_err;
    rd = 32'h0;
    if (legal && !we && !s_err) begin
      v = {32'h0, srd} >> (8 * off);
      m = (64'd1 << (8 * nb)) - 64'd1;
      v = v & m;
      if (sgn && nb < 4 && v[8*nb-1]) v = v | ~m;
      rd = v[31:0];
    end
  endfunction

  // Issues one request from a negedge and plays the target; waits<0 means a silent target.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [31:0] wdata, input int waits,
                      input logic [31:0] srd, input logic s_ack, input logic s_err,
                      input int budget, output logic got, output logic [31:0] rd,
                      output logic er, output int lat, output int cyc_n, output logic stable,
                      output logic [3:0] sel_s, output logic [31:0] wd_s,
                      output logic [31:0] ad_s, output logic we_s);
    int k;
    got = 0; rd = 0; er = 0; lat = 0; cyc_n = 0; stable = 1;
    sel_s = 0; wd_s = 0; ad_s = 0; we_s = 0;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_accept", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_wdata  = $urandom;
    while (lat < budget) begin
      bus_if.ack   = 1'b0;
      bus_if.err   = 1'b0;
      bus_if.rdata = $urandom;
      if (rsp_valid) begin
        got = 1;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
      if (bus_if.cyc) begin
        if (cyc_n == 0) begin
          sel_s = bus_if.sel; wd_s = bus_if.wdata; ad_s = bus_if.addr; we_s = bus_if.we;
          if (bus_if.stb !== 1'b1) stable = 0;
        end else if (bus_if.sel !== sel_s || bus_if.wdata !== wd_s || bus_if.addr !== ad_s ||
                     bus_if.we !== we_s || bus_if.stb !== 1'b1) begin
          stable = 0;
        end
        if (cyc_n == waits) begin
          bus_if.ack   = s_ack;
          bus_if.err   = s_err;
          bus_if.rdata = srd;
        end
        cyc_n++;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    bus_if.ack = 1'b0;
    bus_if.err = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic got, er, stable, we_s;
    logic [31:0] rd, wd_s, ad_s;
    logic [3:0] sel_s;
    int lat, cyc_n;
    xfer(v.we, v.addr, v.size, v.sgn, v.wdata, v.waits, v.srd, v.ack, v.err, 50,
         got, rd, er, lat, cyc_n, stable, sel_s, wd_s, ad_s, we_s);
    check({tag, " rsp_seen"}, {31'h0, got}, 32'h1);
    check({tag, " rsp_err"}, {31'h0, er}, {31'h0, v.er});
    check({tag, " rsp_rdata"}, rd, v.rd);
    if (v.legal) begin
      check({tag, " sel"}, {28'h0, sel_s}, {28'h0, v.sel});
      check({tag, " bus_wdata"}, wd_s, v.bwd);
      check({tag, " bus_we"}, {31'h0, we_s}, {31'h0, v.we});
      check({tag, " bus_addr"}, ad_s, {v.addr[31:2], 2'b00});
      check({tag, " cyc_cycles"}, cyc_n, v.waits + 1);
      check({tag, " bus_stable"}, {31'h0, stable}, 32'h1);
      check({tag, " latency"}, lat, v.waits + 1);
    end else begin
      check({tag, " cyc_cycles"}, cyc_n, 0);
      check({tag, " latency"}, lat, 0);
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, " rsp_one_cycle"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    logic got, er, stable, we_s;
    logic [31:0] rd, wd_s, ad_s;
    logic [3:0] sel_s;
    int lat, cyc_n;
    vec_t rv;

    //          we    addr          sz     sgn   wdata         w  srd           ack   err   legal sel      bwd           rd            er
    vecs[0]  = '{1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0,        0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_1003, 2'b00, 1'b1, 32'h0,        0, 32'h80000000, 1'b1, 1'b0, 1'b1, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_1003, 2'b00, 1'b0, 32'h0,        0, 32'h80000000, 1'b1, 1'b0, 1'b1, 4'b1000, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h0000ABCD, 4, 32'h12345678, 1'b1, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h0000_1001, 2'b10, 1'b0, 32'h0,        0, 32'h0,        1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0,        1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 4'b1111, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h0000_3000, 2'b11, 1'b0, 32'h0,        0, 32'h0,        1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0000_4002, 2'b01, 1'b1, 32'h0,        2, 32'h80011234, 1'b1, 1'b0, 1'b1, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_5001, 2'b00, 1'b0, 32'h12345678, 0, 32'h0,        1'b1, 1'b0, 1'b1, 4'b0010, 32'h78787878, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h0000_4000, 2'b01, 1'b0, 32'h0,        1, 32'h1234F00D, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h0,        32'h0000F00D, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_6000, 2'b10, 1'b0, 32'h11223344, 3, 32'h0,        1'b0, 1'b1, 1'b1, 4'b1111, 32'h11223344, 32'h0,        1'b1};

    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'h0;
    bus_if.ack = 1'b0; bus_if.err = 1'b0; bus_if.rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'h0, req_ready}, 32'h0);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'h0, rsp_err}, 32'h0);
    check("reset cyc", {31'h0, bus_if.cyc}, 32'h0);
    check("reset stb", {31'h0, bus_if.stb}, 32'h0);
    check("reset we", {31'h0, bus_if.we}, 32'h0);
    check("reset sel", {28'h0, bus_if.sel}, 32'h0);
    check("reset addr", bus_if.addr, 32'h0);
    check("reset wdata", bus_if.wdata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      int r;
      rv.we    = 1'($urandom);
      r        = $urandom_range(0, 9);
      rv.size  = (r == 0) ? 2'b11 : 2'(r % 3);
      rv.addr  = $urandom;
      if (rv.size != 2'b11 && $urandom_range(0, 1) == 1)
        rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
      rv.sgn   = 1'($urandom);
      rv.wdata = $urandom;
      rv.waits = $urandom_range(0, 3);
      rv.srd   = $urandom;
      r        = $urandom_range(0, 5);
      rv.err   = (r <= 1);
      rv.ack   = (r != 0);
      model(rv.we, rv.addr, rv.size, rv.sgn, rv.wdata, rv.srd, rv.err,
            rv.legal, rv.sel, rv.bwd, rv.rd, rv.er);
      run_vec(rv, $sformatf("rand%0d", i));
    end

`ifdef WB_MASTER_TIMEOUT_EN
    xfer(1'b0, 32'h0000_7000, 2'b10, 1'b0, 32'h0, -1, 32'h0, 1'b1, 1'b0, 50,
         got, rd, er, lat, cyc_n, stable, sel_s, wd_s, ad_s, we_s);
    check("timeout rsp_seen", {31'h0, got}, 32'h1);
    check("timeout rsp_err", {31'h0, er}, 32'h1);
    check("timeout rsp_rdata", rd, 32'h0);
    check("timeout cyc_cycles", cyc_n, int'(TO));
    check("timeout bus_stable", {31'h0, stable}, 32'h1);
    bus_if.ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.ack = 1'b0;
    check("late_ack no rsp", {31'h0, rsp_valid}, 32'h0);
    check("late_ack no cyc", {31'h0, bus_if.cyc}, 32'h0);
`else
    xfer(1'b0, 32'h0000_7000, 2'b10, 1'b0, 32'h0, -1, 32'h0, 1'b1, 1'b0, 1000,
         got, rd, er, lat, cyc_n, stable, sel_s, wd_s, ad_s, we_s);
    check("no_timeout rsp_seen", {31'h0, got}, 32'h0);
    check("no_timeout cyc_cycles", cyc_n, 1000);
    check("no_timeout bus_stable", {31'h0, stable}, 32'h1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
`endif

    xfer(1'b1, 32'h0000_8000, 2'b10, 1'b0, 32'h55AA55AA, -1, 32'h0, 1'b1, 1'b0, 4,
         got, rd, er, lat, cyc_n, stable, sel_s, wd_s, ad_s, we_s);
    check("midreset cyc_before", {31'h0, bus_if.cyc}, 32'h1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset cyc", {31'h0, bus_if.cyc}, 32'h0);
    check("midreset stb", {31'h0, bus_if.stb}, 32'h0);
    check("midreset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset rsp_after", {31'h0, rsp_valid}, 32'h0);
    run_vec(vecs[0], "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
